// File: rtl/mvm_engine_p.sv
// mvm_engine_p: sequential matrix-vector multiplier.
//   Loads a LANES-entry signed vector X and a ROWS x LANES signed matrix W
//   through a write port. It then produces one saturated (and optionally
//   ReLU-clamped) dot product per W row, using a valid/ready handshake.
// Ports:
//   clk, rst (sync, active-low)          clock and reset
//   in_valid, in_sel, in_addr, in_data   storage write port (0 = X, 1 = W)
//   start, relu_en                       run request and ReLU select
//   busy, done                           run status / end-of-run pulse
//   out_valid, out_ready                 result handshake
//   out_data, out_row                    row result and its row index
//   sat_flag                             sticky saturation of current/last run
module mvm_engine_p #(
    parameter  int DATA_W = 14,
    parameter  int LANES  = 8,
    parameter  int ROWS   = 8,
    localparam int ACC_W  = 2 * DATA_W,
    localparam int AW     = (LANES * ROWS > 1) ? $clog2(LANES * ROWS) : 1,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sel,
    input  logic [AW-1:0]            in_addr,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     start,
    input  logic                     relu_en,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [RW-1:0]            out_row,
    output logic                     sat_flag
);

    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SUM_W = ACC_W + $clog2(LANES);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] MIN_S = ~MAX_S;

    typedef enum logic [2:0] {IDLE, READ, MULT, SUM, OUT} state_t;

    state_t                    r_state;
    logic [RW-1:0]             r_row;
    logic                      r_relu;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_out_valid;
    logic signed [ACC_W-1:0]   r_out_data;
    logic [RW-1:0]             r_out_row;
    logic                      r_sat;

    logic signed [DATA_W-1:0]  r_x    [LANES];
    logic signed [DATA_W-1:0]  r_w    [ROWS][LANES];
    logic signed [DATA_W-1:0]  r_wrow [LANES];
    logic signed [ACC_W-1:0]   r_prod [LANES];

    logic [LW-1:0]             w_lane;
    logic [RW-1:0]             w_wr_row;
    logic                      w_addr_ok;
    logic signed [SUM_W-1:0]   w_sum;
    logic                      w_clamp;
    logic signed [ACC_W-1:0]   w_result;

    // Write address decode: X uses only the lane part of the address.
    always_comb begin
        w_lane    = LW'(32'(in_addr) % LANES);
        w_wr_row  = RW'(32'(in_addr) / LANES);
        w_addr_ok = 32'(in_addr) < 32'(LANES * ROWS);
    end

    // Storage has no reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && in_valid) begin
            if (!in_sel)
                r_x[w_lane] <= in_data;
            else if (w_addr_ok)
                r_w[w_wr_row][w_lane] <= in_data;
        end
    end

    // Pipeline datapath: row fetch, then lane-wise products.
    always_ff @(posedge clk) begin
        if (r_state == READ) begin
            for (int unsigned i = 0; i < LANES; i++)
                r_wrow[LW'(i)] <= r_w[r_row][LW'(i)];
        end
        if (r_state == MULT) begin
            for (int unsigned i = 0; i < LANES; i++)
                r_prod[LW'(i)] <= r_wrow[LW'(i)] * r_x[LW'(i)];
        end
    end

    // Exact sum at full width, a single clamp, then optional ReLU.
    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < LANES; i++)
            w_sum = w_sum + SUM_W'(r_prod[LW'(i)]);
        w_clamp = 1'b0;
        if (w_sum > MAX_S) begin
            w_result = {1'b0, {(ACC_W-1){1'b1}}};
            w_clamp  = 1'b1;
        end else if (w_sum < MIN_S) begin
            w_result = {1'b1, {(ACC_W-1){1'b0}}};
            w_clamp  = 1'b1;
        end else begin
            w_result = w_sum[ACC_W-1:0];
        end
        if (r_relu && w_result[ACC_W-1])
            w_result = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_relu      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= READ;
                        r_row   <= '0;
                        r_relu  <= relu_en;
                        r_sat   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                READ: r_state <= MULT;
                MULT: r_state <= SUM;
                SUM: begin
                    r_out_data  <= w_result;
                    r_out_row   <= r_row;
                    r_out_valid <= 1'b1;
                    if (w_clamp)
                        r_sat <= 1'b1;
                    r_state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_row == RW'(ROWS - 1)) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_state <= READ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_row   = r_out_row;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_mvm_engine_p.sv
// tb_mvm_engine_p: directed self-checking bench for mvm_engine_p.
//   Each scenario task loads X/W, runs the engine and compares the
//   collected row results against hand-computed values.
module tb_mvm_engine_p;

    localparam int DATA_W = 14;
    localparam int LANES  = 8;
    localparam int ROWS   = 8;
    localparam int ACC_W  = 28;
    localparam int AW     = 6;
    localparam int RW     = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_sel;
    logic [AW-1:0]            in_addr;
    logic signed [DATA_W-1:0] in_data;
    logic                     start;
    logic                     relu_en;
    logic                     busy;
    logic                     done;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic [RW-1:0]            out_row;
    logic                     sat_flag;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [ACC_W-1:0] res_data [ROWS];
    logic [RW-1:0]           res_row  [ROWS];
    int   first_lat, n_rows, n_done, unstable, gap_bad;
    logic timeout, busy_after, done_after;

    mvm_engine_p #(.DATA_W(DATA_W), .LANES(LANES), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .start     (start),
        .relu_en   (relu_en),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    task automatic wr(input logic sel, input int addr, input int val);
        in_valid = 1'b1;
        in_sel   = sel;
        in_addr  = AW'(addr);
        in_data  = DATA_W'(val);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // w_by_row=1 loads W row r with value r in every lane, else all wv.
    task automatic load(input int xv, input int wv, input logic w_by_row);
        for (int l = 0; l < LANES; l++) wr(1'b0, l, xv);
        for (int a = 0; a < LANES * ROWS; a++) wr(1'b1, a, w_by_row ? a / LANES : wv);
    endtask

    // Runs one full pass, capturing each row result. Optionally stalls one
    // row for 5 cycles, pokes start/in_valid while busy, or writes X[0]=5
    // on the start edge.
    task automatic do_run(input logic relu, input int stall_row, input logic poke,
                          input logic same_wr);
        int lat, cyc;
        out_ready = 1'b0;
        start     = 1'b1;
        relu_en   = relu;
        if (same_wr) begin
            in_valid = 1'b1; in_sel = 1'b0; in_addr = '0; in_data = 14'sd5;
        end
        @(posedge clk); #1;
        start = 1'b0; relu_en = 1'b0; in_valid = 1'b0;
        n_rows = 0; n_done = 0; unstable = 0; gap_bad = 0;
        timeout = 1'b0; first_lat = -1; lat = 0; cyc = 0;
        while (n_rows < ROWS && !timeout) begin
            if (done) n_done++;
            start = 1'b0; in_valid = 1'b0;
            if (out_valid) begin
                if (n_rows == 0) first_lat = lat;
                else if (lat != 3) gap_bad++;
                res_data[n_rows] = out_data;
                res_row[n_rows]  = out_row;
                if (stall_row >= 0 && int'(out_row) == stall_row) begin
                    for (int k = 0; k < 5; k++) begin
                        out_ready = 1'b0;
                        @(posedge clk); #1;
                        if (!out_valid || out_data !== res_data[n_rows] ||
                            out_row !== res_row[n_rows]) unstable++;
                    end
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                n_rows++;
                lat = 0;
            end else begin
                if (poke) begin
                    start = 1'b1; in_valid = 1'b1; in_sel = cyc[0];
                    in_addr = AW'(cyc); in_data = 14'sd100;
                end
                @(posedge clk); #1;
                lat++;
            end
            cyc++;
            if (cyc > 300) timeout = 1'b1;
        end
        start = 1'b0; in_valid = 1'b0;
        busy_after = busy;
        done_after = done;
        if (done) n_done++;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0)    begin n_bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        n_cmp++; if (out_row !== '0)     begin n_bad++; $display("FAIL reset_out_row: got %0d expected 0", out_row); end
        n_cmp++; if (sat_flag !== 1'b0)  begin n_bad++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic signed [ACC_W-1:0] e;
        load(1, 0, 1'b1);
        do_run(1'b0, -1, 1'b0, 1'b0);
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b expected 0", timeout); end
        n_cmp++; if (first_lat != 3)   begin n_bad++; $display("FAIL basic_latency: got %0d expected 3", first_lat); end
        n_cmp++; if (gap_bad != 0)     begin n_bad++; $display("FAIL basic_row_gap: got %0d bad gaps expected 0", gap_bad); end
        for (int r = 0; r < ROWS; r++) begin
            e = ACC_W'(8 * r);
            n_cmp++; if (res_data[r] !== e)     begin n_bad++; $display("FAIL basic_data[%0d]: got %0d expected %0d", r, res_data[r], e); end
            n_cmp++; if (res_row[r] !== RW'(r)) begin n_bad++; $display("FAIL basic_row[%0d]: got %0d expected %0d", r, res_row[r], r); end
        end
        n_cmp++; if (n_done != 1)         begin n_bad++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
        n_cmp++; if (done_after !== 1'b1) begin n_bad++; $display("FAIL basic_done_pulse: got %b expected 1", done_after); end
        n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b expected 0", busy_after); end
        n_cmp++; if (sat_flag !== 1'b0)   begin n_bad++; $display("FAIL basic_sat: got %b expected 0", sat_flag); end
        n_cmp++; if (out_row !== RW'(7))  begin n_bad++; $display("FAIL basic_idle_hold_row: got %0d expected 7", out_row); end
    endtask

    task automatic test_same_edge_write;
        logic signed [ACC_W-1:0] e;
        do_run(1'b0, -1, 1'b0, 1'b1);
        for (int r = 0; r < ROWS; r++) begin
            e = ACC_W'(12 * r);
            n_cmp++; if (res_data[r] !== e) begin n_bad++; $display("FAIL same_edge_data[%0d]: got %0d expected %0d", r, res_data[r], e); end
        end
        wr(1'b0, 0, 1);
    endtask

    task automatic test_saturate;
        logic signed [ACC_W-1:0] e;
        load(8191, 8191, 1'b0);
        do_run(1'b0, -1, 1'b0, 1'b0);
        e = ACC_W'(134217727);
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (res_data[r] !== e) begin n_bad++; $display("FAIL sat_pos_data[%0d]: got %0d expected %0d", r, res_data[r], e); end
        end
        n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_pos_flag: got %b expected 1", sat_flag); end
        load(-8192, 8191, 1'b0);
        do_run(1'b0, -1, 1'b0, 1'b0);
        e = ACC_W'(-134217728);
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (res_data[r] !== e) begin n_bad++; $display("FAIL sat_neg_data[%0d]: got %0d expected %0d", r, res_data[r], e); end
        end
        n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_neg_flag: got %b expected 1", sat_flag); end
    endtask

    task automatic test_relu;
        logic signed [ACC_W-1:0] e;
        load(-1, 1, 1'b0);
        do_run(1'b1, -1, 1'b0, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (res_data[r] !== '0) begin n_bad++; $display("FAIL relu_on_data[%0d]: got %0d expected 0", r, res_data[r]); end
        end
        n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL relu_sat_cleared: got %b expected 0", sat_flag); end
        do_run(1'b0, -1, 1'b0, 1'b0);
        e = ACC_W'(-8);
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (res_data[r] !== e) begin n_bad++; $display("FAIL relu_off_data[%0d]: got %0d expected %0d", r, res_data[r], e); end
        end
    endtask

    task automatic test_stall;
        load(1, 0, 1'b1);
        do_run(1'b0, 2, 1'b0, 1'b0);
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes expected 0", unstable); end
        n_cmp++; if (n_rows != ROWS) begin n_bad++; $display("FAIL stall_rows: got %0d expected %0d", n_rows, ROWS); end
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (res_row[r] !== RW'(r) || res_data[r] !== ACC_W'(8 * r))
                begin n_bad++; $display("FAIL stall_row[%0d]: got row %0d data %0d expected row %0d data %0d", r, res_row[r], res_data[r], r, 8 * r); end
        end
    endtask

    task automatic test_reset_midrun;
        logic found;
        found = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #1;
            if (out_valid && out_row == RW'(3)) found = 1'b1;
        end
        out_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_cmp++; if (found !== 1'b1)      begin n_bad++; $display("FAIL midrun_reach_row3: got %b expected 1", found); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL midrun_busy: got %b expected 0", busy); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL midrun_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0)     begin n_bad++; $display("FAIL midrun_out_data: got %0d expected 0", out_data); end
        n_cmp++; if (out_row !== '0)      begin n_bad++; $display("FAIL midrun_out_row: got %0d expected 0", out_row); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL midrun_done: got %b expected 0", done); end
        @(posedge clk); #1;
        do_run(1'b0, -1, 1'b0, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (res_row[r] !== RW'(r) || res_data[r] !== ACC_W'(8 * r))
                begin n_bad++; $display("FAIL midrun_rerun[%0d]: got row %0d data %0d expected row %0d data %0d", r, res_row[r], res_data[r], r, 8 * r); end
        end
    endtask

    task automatic test_busy_ignore;
        do_run(1'b0, -1, 1'b1, 1'b0);
        n_cmp++; if (n_done != 1)         begin n_bad++; $display("FAIL busy_ign_done_count: got %0d expected 1", n_done); end
        n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL busy_ign_busy_end: got %b expected 0", busy_after); end
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (res_row[r] !== RW'(r) || res_data[r] !== ACC_W'(8 * r))
                begin n_bad++; $display("FAIL busy_ign_run[%0d]: got row %0d data %0d expected row %0d data %0d", r, res_row[r], res_data[r], r, 8 * r); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_ign_no_restart: got %b expected 0", busy); end
        do_run(1'b0, -1, 1'b0, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (res_data[r] !== ACC_W'(8 * r))
                begin n_bad++; $display("FAIL busy_ign_storage[%0d]: got %0d expected %0d", r, res_data[r], 8 * r); end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_addr = '0; in_data = '0;
        start = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_same_edge_write();
        test_saturate();
        test_relu();
        test_stall();
        test_reset_midrun();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mvm_engine_p.md
MVM_ENGINE_P -- requirements
Module: mvm_engine_p

Interface
REQ-001 SHALL have parameter DATA_W, default 14: signed width of X and W elements.
REQ-002 SHALL have parameter LANES, default 8: vector length (X entries, multipliers per row).
REQ-003 SHALL have parameter ROWS, default 8: W rows (number of output results per run).
REQ-004 SHALL have derived ACC_W = 2*DATA_W (signed result width) and AW = clog2(LANES*ROWS).
REQ-005 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-007 SHALL have port in_valid  in  1  write strobe for in_data.
REQ-008 SHALL have port in_sel  in  1  write target, 0 = X, 1 = W.
REQ-009 SHALL have port in_addr  in  AW  X: lane = in_addr mod LANES; W: row = in_addr / LANES, lane = in_addr mod LANES.
REQ-010 SHALL have port in_data  in  DATA_W  signed element.
REQ-011 SHALL have port start  in  1  run request, sampled only in IDLE.
REQ-012 SHALL have port relu_en  in  1  clamp negative results to 0, sampled with start.
REQ-013 SHALL have port busy  out  1  high from start acceptance until the last row is accepted.
REQ-014 SHALL have port done  out  1  one-cycle pulse at end of run.
REQ-015 SHALL have port out_valid  out  1, out_ready  in  1  result handshake.
REQ-016 SHALL have port out_data  out  ACC_W  signed row result; out_row  out  clog2(ROWS)  its row index.
REQ-017 SHALL have port sat_flag  out  1  sticky: some row of current/last run saturated.

Function
REQ-018 SHALL write X/W storage on an edge with in_valid=1 only while in IDLE; writes in any other state SHALL be ignored.
REQ-019 SHALL use FSM states IDLE, READ, MULT, SUM, OUT.
REQ-020 IDLE: start=1 -> READ, row=0, relu latched, sat_flag cleared; a same-edge in_valid write SHALL also take effect and be visible to the run.
REQ-021 READ -> MULT: W row registered. MULT -> SUM: LANES signed DATA_W x DATA_W products registered (full 2*DATA_W).
REQ-022 SUM: SHALL form the exact sum of all products (ACC_W+clog2(LANES) bits), then clamp once to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; clamping SHALL set sat_flag; if relu latched, negative -> 0 (after clamp); register into out_data, out_row=row -> OUT.
REQ-023 Latency: out_valid SHALL rise after the 3rd edge following start acceptance, and after the 3rd edge following each non-final handshake.
REQ-024 OUT: out_valid=1; out_data/out_row SHALL hold stable until out_valid&&out_ready at an edge.
REQ-025 Handshake, row<ROWS-1 -> row+1, READ; row=ROWS-1 -> IDLE, busy=0, done=1 for exactly that next cycle.
REQ-026 start while not IDLE SHALL be ignored; out_ready outside OUT SHALL have no effect.
REQ-027 out_data, out_row and sat_flag SHALL retain last values in IDLE until next start.

Reset
REQ-028 rst=0 at an edge SHALL force IDLE, busy=0, done=0, out_valid=0, out_data=0, out_row=0, sat_flag=0, row=0, from any state including mid-run.
REQ-029 X and W storage SHALL NOT be cleared by reset; contents are retained across reset.

Verification
REQ-030 X all 1, W row r all r, relu_en=0, out_ready=1 -> rows 0..7 out_data = 8r, out_row=r, first out_valid 3 cycles after start, done pulse once, sat_flag=0.
REQ-031 X all 8191, W all 8191 -> every out_data = 134217727, sat_flag=1; X all -8192, W all 8191 -> out_data = -134217728.
REQ-032 out_ready=0 for 5 cycles on row 2 -> out_data/out_row stable throughout, no row skipped or repeated.
REQ-033 X all -1, W all 1, relu_en=1 -> all out_data = 0; same with relu_en=0 -> -8.
REQ-034 rst=0 during row 3 -> next cycle busy=0, out_valid=0, out_data=0; new start -> full REQ-030 results (memories retained).
REQ-035 start and in_valid asserted while busy -> no restart, no storage change, results unchanged.
